display_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the calculator's multi-digit seven-segment display.
- Latches a packed hex/BCD result plus a sign flag through a ready/load handshake.
- Cycles a single shared hex-to-segment decoder across all digit positions and drives active-low anode and segment lines.
- Applies leading-zero blanking and minus-sign placement, and inserts an anti-ghosting guard interval between digit slots.

---
 rtl/display_scan_ctrl_pkg.sv | 19 +
 rtl/display_scan_ctrl_hex2segments.sv | 31 +++
 rtl/display_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package display_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK      = 7'b1111111;
  localparam logic [6:0] SEG_MINUS      = 7'b0111111;
  localparam logic [3:0] HEX_BLANK_CODE = 4'hF;

  typedef enum logic [0:0] {
    HS_IDLE,
    HS_PEND
  } hs_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_hex2segments.sv
// Shared nibble-to-segment decoder; code 15 is reserved as the blank pattern.
module hex2segments
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with load handshake,
// leading-zero blanking, minus placement and an anti-ghosting guard.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    neg_in,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int PW = width_of(CLK_DIV);
  localparam int IW = width_of(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_P   = PW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_tick, frame_tick;

  hs_state_e state_q, state_d;
  logic      capture, commit;

  logic [4*NUM_DIGITS-1:0] pend_q, disp_q;
  logic                    pend_neg_q, disp_neg_q;

  logic [NUM_DIGITS-1:0] blank, minus;
  logic                  nz_seen;
  logic [3:0]            sel_code;
  logic [6:0]            dec_seg, sym_seg;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic [6:0]            seg_q;

  assign slot_tick  = (presc_q == PRESC_MAX);
  assign frame_tick = slot_tick && (idx_q == IDX_MAX);

  always_comb begin
    presc_d = slot_tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (slot_tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
  end

  // Handshake: a load is taken only in a cycle where ready=1; ready drops
  // the next cycle and returns the cycle after the frame boundary that
  // commits the pending value, so the display never changes mid-frame.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      HS_IDLE: if (load) begin
        capture = 1'b1;
        state_d = HS_PEND;
      end
      HS_PEND: if (frame_tick) begin
        commit  = 1'b1;
        state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
  end

  assign ready = (state_q == HS_IDLE);

  // Blanks grow down from the top; the minus takes the lowest blank, or every
  // position when the number fills the display.
  always_comb begin
    nz_seen = 1'b0;
    blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_seen  = nz_seen | (disp_q[4*i +: 4] != 4'h0);
      blank[i] = (i != 0) && !nz_seen;
    end
    minus    = '0;
    minus[0] = disp_neg_q && (blank == '0);
    for (int i = 1; i < NUM_DIGITS; i++)
      minus[i] = disp_neg_q && ((blank == '0) || (blank[i] && !blank[i-1]));
  end

  assign sel_code = blank[idx_q] ? HEX_BLANK_CODE : disp_q[{idx_q, 2'b00} +: 4];

  hex2segments u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

  assign sym_seg = minus[idx_q] ? SEG_MINUS : dec_seg;

  // Anodes are registered from the next prescaler value so the dark guard
  // lines up exactly with prescaler counts 0..GUARD-1 of each slot.
  always_comb begin
    an_d = '1;
    if (presc_d >= GUARD_P) an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      state_q    <= HS_IDLE;
      pend_q     <= '0;
      pend_neg_q <= 1'b0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      if (capture) begin
        pend_q     <= value_in;
        pend_neg_q <= neg_in;
      end
      if (commit) begin
        disp_q     <= pend_q;
        disp_neg_q <= pend_neg_q;
      end
      an_q  <= an_d;
      seg_q <= sym_seg;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed-plus-random bench for display_scan_ctrl against a cycle-count
// reference model of the scan, handshake and symbol rules.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int CD    = 8;
  localparam int G     = 2;
  localparam int FRAME = N * CD;
  localparam int W     = 4 * N + 1;

  logic            clk;
  logic            rst_n;
  logic            load;
  logic [4*N-1:0]  value_in;
  logic            neg_in;
  logic            ready;
  logic [N-1:0]    an;
  logic [6:0]      seg;

  int total;
  int bad;

  // Reference model state.
  int          t;
  bit          rdy;
  logic [W-1:0] disp;
  logic [W-1:0] exp_q[$];

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b1111111
  };

  display_scan_ctrl #(
    .NUM_DIGITS (N),
    .CLK_DIV    (CD),
    .GUARD      (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value_in (value_in),
    .neg_in   (neg_in),
    .ready    (ready),
    .an       (an),
    .seg      (seg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp_v, t);
    end
  endtask

  // Symbol for display position pos given {neg, value}.
  function automatic logic [6:0] exp_seg(input logic [W-1:0] v, input int pos);
    int  msd = 0;
    logic neg = v[W-1];
    for (int i = 0; i < N; i++)
      if (v[4*i +: 4] != 4'h0) msd = i;
    if (pos > msd) return (neg && pos == msd + 1) ? 7'b0111111 : 7'b1111111;
    if (neg && msd == N - 1) return 7'b0111111;
    return seg_tab[v[4*pos +: 4]];
  endfunction

  // One clock: advance the model at the edge, then check outputs mid-cycle.
  task automatic tick();
    int         presc;
    int         idx;
    logic [N-1:0] one;
    logic [N-1:0] exp_an;
    @(posedge clk);
    if (!rst_n) begin
      t   = 0;
      rdy = 1'b1;
      disp = '0;
      exp_q.delete();
    end else begin
      if ((t % FRAME) == FRAME - 1 && !rdy) begin
        disp = exp_q.pop_front();
        rdy  = 1'b1;
      end else if (load && rdy) begin
        exp_q.push_back({neg_in, value_in});
        rdy = 1'b0;
      end
      t++;
    end
    @(negedge clk);
    presc  = t % CD;
    idx    = (t / CD) % N;
    one    = 1;
    exp_an = (presc < G) ? '1 : ~(one << idx);
    chk("an", 32'(an), 32'(exp_an));
    chk("ready", 32'(ready), 32'(rdy));
    chk("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (!rst_n) chk("seg_reset", 32'(seg), 32'h7F);
    if (exp_an != '1) chk("seg", 32'(seg), 32'(exp_seg(disp, idx)));
  endtask

  // Driver: present a load request for one cycle.
  task automatic do_load(input logic [4*N-1:0] v, input logic n);
    load     = 1'b1;
    value_in = v;
    neg_in   = n;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget && ready !== 1'b1; k++) tick();
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [4*N-1:0] v;
    int             lz;
    total    = 0;
    bad      = 0;
    t        = 0;
    rdy      = 1'b1;
    disp     = '0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = '0;
    neg_in   = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();

    // First value, with an ignored second load while pending.
    do_load(16'h1A3F, 1'b0);
    repeat (6) tick();
    do_load(16'h5555, 1'b0);
    repeat (70) tick();

    wait_ready(100);
    do_load(16'h0042, 1'b1);
    repeat (70) tick();

    wait_ready(100);
    do_load(16'h9999, 1'b1);
    repeat (70) tick();

    // Load accepted in the frame-boundary cycle waits a whole extra frame.
    wait_ready(100);
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != FRAME - 1; k++) tick();
    do_load(16'h0007, 1'b0);
    repeat (75) tick();

    // Random values with random leading-zero counts and signs.
    for (int r = 0; r < 12; r++) begin
      wait_ready(100);
      repeat ($urandom_range(0, 9)) tick();
      lz = $urandom_range(0, N);
      v  = 16'($urandom);
      v  = (lz == N) ? '0 : (v >> (4 * lz));
      do_load(v, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 20)) tick();
      do_load(16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(40, 70)) tick();
    end

    // Reset in the middle of a slot with a load pending.
    wait_ready(100);
    do_load(16'h0123, 1'b1);
    repeat (13) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
